// File: rtl/bk_sram_sched.sv
`timescale 1ns/1ps
// bk_sram_sched: arbitrates one 16-bit async SRAM between video refresh,
// CPU bus cycles and the debug host port using 16-cycle slot frames.
// Slot 0 belongs to video; CPU/debug run IDLE->ACC->DONE transactions
// granted in slots 1..13 so they never collide with the video access.
module bk_sram_sched #(
  parameter logic [4:0]  VID_BANK = 5'b00001,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk25,
  input  logic              reset_in,
  input  logic [3:0]        slot_i,
  input  logic [12:0]       vid_addr_i,
  output logic              vid_load_o,
  input  logic              cpu_rd_i,
  input  logic              cpu_wt_i,
  input  logic [15:0]       cpu_adr_i,
  input  logic              cpu_byte_i,
  input  logic [DATA_W-1:0] cpu_dout_i,
  output logic [DATA_W-1:0] cpu_din_o,
  output logic              cpu_reply_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_lb_n_o,
  output logic              sram_ub_n_o
);

  localparam int unsigned SLOT_W = 4;
  localparam int unsigned CPU_AW = 16;
  localparam logic [SLOT_W-1:0] SLOT_VID  = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(13);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rd_q, wt_q;
  logic                cpu_pend_q, cpu_pend_d;
  logic                cpu_wr_q, cpu_wr_d;
  logic                dbg_pend_q, dbg_pend_d;
  logic                fair_q, fair_d;
  logic                own_dbg_q, own_dbg_d;
  logic                own_wr_q, own_wr_d;
  logic                vid_ph_q, vid_ph_d;
  logic                vid_load_q, vid_load_d;
  logic                cpu_reply_q, cpu_reply_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   cpu_din_q, cpu_din_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic                dq_oe_q, dq_oe_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;

  logic                rd_edge, wt_edge, cpu_edge;
  logic                cpu_req, cpu_req_wr;
  logic                dbg_set, dbg_req;
  logic                slot_ok, pick_dbg;

  // State, request tracking and registered bus/handshake outputs
  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wt_q        <= 1'b0;
      cpu_pend_q  <= 1'b0;
      cpu_wr_q    <= 1'b0;
      dbg_pend_q  <= 1'b0;
      fair_q      <= 1'b0;
      own_dbg_q   <= 1'b0;
      own_wr_q    <= 1'b0;
      vid_ph_q    <= 1'b0;
      vid_load_q  <= 1'b0;
      cpu_reply_q <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_din_q   <= '0;
      dbg_rdata_q <= '0;
      addr_q      <= '0;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_q        <= cpu_rd_i;
      wt_q        <= cpu_wt_i;
      cpu_pend_q  <= cpu_pend_d;
      cpu_wr_q    <= cpu_wr_d;
      dbg_pend_q  <= dbg_pend_d;
      fair_q      <= fair_d;
      own_dbg_q   <= own_dbg_d;
      own_wr_q    <= own_wr_d;
      vid_ph_q    <= vid_ph_d;
      vid_load_q  <= vid_load_d;
      cpu_reply_q <= cpu_reply_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_din_q   <= cpu_din_d;
      dbg_rdata_q <= dbg_rdata_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      dq_oe_q     <= dq_oe_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
    end
  end

  // Next-state: request capture, arbitration, transaction sequencing, video slot
  always_comb begin
    state_d     = state_q;
    cpu_pend_d  = cpu_pend_q;
    cpu_wr_d    = cpu_wr_q;
    dbg_pend_d  = dbg_pend_q;
    fair_d      = fair_q;
    own_dbg_d   = own_dbg_q;
    own_wr_d    = own_wr_q;
    cpu_din_d   = cpu_din_q;
    dbg_rdata_d = dbg_rdata_q;
    addr_d      = addr_q;
    dq_d        = dq_q;
    dq_oe_d     = 1'b0;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    dbg_ack_d   = 1'b0;
    pick_dbg    = 1'b0;

    rd_edge    = cpu_rd_i & ~rd_q;
    wt_edge    = cpu_wt_i & ~wt_q;
    cpu_edge   = rd_edge | wt_edge;
    // A fresh edge can be granted in the same cycle it is seen
    cpu_req    = cpu_pend_q | cpu_edge;
    cpu_req_wr = cpu_edge ? wt_edge : cpu_wr_q;
    // Ack cycle still counts as outstanding so a held request is not re-latched
    dbg_set    = dbg_req_i & (state_q == IDLE) & ~dbg_pend_q & ~dbg_ack_q;
    dbg_req    = dbg_pend_q | dbg_set;
    slot_ok    = (slot_i != SLOT_VID) && (slot_i <= SLOT_LAST);

    vid_ph_d    = (slot_i == SLOT_VID);
    vid_load_d  = vid_ph_q;
    cpu_reply_d = cpu_reply_q & (cpu_rd_i | cpu_wt_i);

    if (dbg_set) begin
      dbg_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (slot_ok && (cpu_req || dbg_req)) begin
          pick_dbg  = dbg_req & (~cpu_req | fair_q);
          fair_d    = ~fair_q;
          state_d   = ACC;
          own_dbg_d = pick_dbg;
          if (pick_dbg) begin
            own_wr_d = dbg_we_i;
            addr_d   = dbg_addr_i;
            dq_d     = dbg_wdata_i;
            lb_n_d   = 1'b0;
            ub_n_d   = 1'b0;
          end else begin
            own_wr_d = cpu_req_wr;
            addr_d   = ADDR_W'({3'b000, cpu_adr_i[CPU_AW-1:1]});
            dq_d     = cpu_dout_i;
            lb_n_d   = cpu_byte_i & cpu_adr_i[0];
            ub_n_d   = cpu_byte_i & ~cpu_adr_i[0];
          end
          if (pick_dbg ? dbg_we_i : cpu_req_wr) begin
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
          end else begin
            oe_n_d  = 1'b0;
          end
        end
      end
      ACC: begin
        // Strobe phase is over; writes keep driving data, reads keep OE low
        state_d = DONE;
        lb_n_d  = lb_n_q;
        ub_n_d  = ub_n_q;
        if (own_wr_q) begin
          dq_oe_d = 1'b1;
        end else begin
          oe_n_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (own_dbg_q) begin
          dbg_pend_d = 1'b0;
          dbg_ack_d  = 1'b1;
          if (!own_wr_q) begin
            dbg_rdata_d = sram_dq_i;
          end
        end else begin
          cpu_pend_d  = 1'b0;
          cpu_reply_d = 1'b1;
          if (!own_wr_q) begin
            cpu_din_d = sram_dq_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cpu_edge) begin
      cpu_pend_d = 1'b1;
      cpu_wr_d   = wt_edge;
    end

    // Video fetch is issued after slot 0; the FSM is always idle here
    if (slot_i == SLOT_VID) begin
      addr_d  = ADDR_W'({VID_BANK, vid_addr_i});
      oe_n_d  = 1'b0;
      we_n_d  = 1'b1;
      lb_n_d  = 1'b0;
      ub_n_d  = 1'b0;
      dq_oe_d = 1'b0;
    end
  end

  assign vid_load_o   = vid_load_q;
  assign cpu_din_o    = cpu_din_q;
  assign cpu_reply_o  = cpu_reply_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign dbg_ack_o    = dbg_ack_q;
  assign sram_addr_o  = addr_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_lb_n_o  = lb_n_q;
  assign sram_ub_n_o  = ub_n_q;

endmodule

// File: tb/tb_bk_sram_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for bk_sram_sched: directed stimulus pushes expected
// transactions, a negedge monitor checks bus starts, strobe shapes,
// completions and the video slot.
module tb_bk_sram_sched;

  logic        clk25 = 1'b0;
  logic        reset_in;
  logic [3:0]  slot_i;
  logic [12:0] vid_addr_i;
  logic        vid_load_o;
  logic        cpu_rd_i, cpu_wt_i;
  logic [15:0] cpu_adr_i;
  logic        cpu_byte_i;
  logic [15:0] cpu_dout_i, cpu_din_o;
  logic        cpu_reply_o;
  logic        dbg_req_i, dbg_we_i;
  logic [17:0] dbg_addr_i;
  logic [15:0] dbg_wdata_i, dbg_rdata_o;
  logic        dbg_ack_o;
  logic [17:0] sram_addr_o;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_dbg;
    bit          we;
    logic [17:0] addr;
    logic [15:0] data;
    bit          lb_n;
    bit          ub_n;
    int          start_slot;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [17:0] VID_EXP = 18'h02ABC;

  always #5 clk25 = ~clk25;

  bk_sram_sched dut (
    .clk25(clk25), .reset_in(reset_in), .slot_i(slot_i),
    .vid_addr_i(vid_addr_i), .vid_load_o(vid_load_o),
    .cpu_rd_i(cpu_rd_i), .cpu_wt_i(cpu_wt_i), .cpu_adr_i(cpu_adr_i),
    .cpu_byte_i(cpu_byte_i), .cpu_dout_i(cpu_dout_i), .cpu_din_o(cpu_din_o),
    .cpu_reply_o(cpu_reply_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_lb_n_o(sram_lb_n_o), .sram_ub_n_o(sram_ub_n_o)
  );

  // Read-only SRAM contents: two seeded words, everything else a fixed pattern
  function automatic logic [15:0] sram_model(input logic [17:0] a);
    case (a)
      18'h00100: sram_model = 16'h1234;
      18'h08000: sram_model = 16'hBEEF;
      default:   sram_model = a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  assign sram_dq_i = sram_oe_n_o ? 16'h0000 : sram_model(sram_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input bit d, input bit w, input logic [17:0] a, input logic [15:0] dat,
                          input bit lb, input bit ub, input int s);
    exp_t e;
    e.is_dbg = d; e.we = w; e.addr = a; e.data = dat;
    e.lb_n = lb; e.ub_n = ub; e.start_slot = s;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk25);
    #2;
  endtask

  task automatic wait_slot(input logic [3:0] s);
    int n = 0;
    do begin
      tick();
      n++;
    end while (slot_i != s && n < 40);
    if (slot_i != s) check("wait_slot", 32'(slot_i), 32'(s));
  endtask

  task automatic cpu_access(input bit wr, input logic [15:0] adr, input bit byt, input logic [15:0] dout);
    int n = 0;
    cpu_adr_i  = adr;
    cpu_byte_i = byt;
    cpu_dout_i = dout;
    if (wr) cpu_wt_i = 1'b1;
    else    cpu_rd_i = 1'b1;
    while (!cpu_reply_o && n < 64) begin
      tick();
      n++;
    end
    check("cpu_reply_seen", 32'(cpu_reply_o), 32'd1);
    tick();
    check("cpu_reply_hold", 32'(cpu_reply_o), 32'd1);
    cpu_rd_i = 1'b0;
    cpu_wt_i = 1'b0;
    tick();
    check("cpu_reply_clear", 32'(cpu_reply_o), 32'd0);
  endtask

  task automatic dbg_access(input bit we, input logic [17:0] a, input logic [15:0] wd);
    int n = 0;
    dbg_we_i    = we;
    dbg_addr_i  = a;
    dbg_wdata_i = wd;
    dbg_req_i   = 1'b1;
    while (!dbg_ack_o && n < 64) begin
      tick();
      n++;
    end
    check("dbg_ack_seen", 32'(dbg_ack_o), 32'd1);
    dbg_req_i = 1'b0;
  endtask

  // Free-running pixel slot counter, changes just after each rising edge
  initial begin
    slot_i = 4'd0;
    forever begin
      @(posedge clk25);
      #1;
      slot_i = slot_i + 4'd1;
    end
  end

  // Monitor: transaction starts, strobe run lengths, completions, video slot
  initial begin
    bit   txn_prev = 1'b0, reply_prev = 1'b0, ack_prev = 1'b0, act, run_wr = 1'b0;
    int   since_rst = 0, run_len = 0, run_we = 0, run_oe = 0;
    exp_t e;
    forever begin
      @(negedge clk25);
      if (reset_in) begin
        since_rst = 0; txn_prev = 1'b0; reply_prev = 1'b0; ack_prev = 1'b0;
        run_len = 0; run_we = 0; run_oe = 0;
      end else begin
        since_rst++;
        if (since_rst >= 4 && slot_i == 4'd1)
          check("vid_bus", 32'({sram_addr_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o, sram_dq_oe_o}),
                32'({VID_EXP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        if (since_rst >= 4 && slot_i == 4'd2) check("vid_load_on", 32'(vid_load_o), 32'd1);
        if (since_rst >= 4 && slot_i == 4'd3) check("vid_load_off", 32'(vid_load_o), 32'd0);

        act = sram_dq_oe_o || !sram_we_n_o || (!sram_oe_n_o && slot_i != 4'd1);
        if (act && !txn_prev) begin
          run_wr = !sram_we_n_o;
          if (exp_q.size() == 0) begin
            check("txn_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q[0];
            check("txn_start", 32'({!sram_we_n_o, sram_addr_o, sram_lb_n_o, sram_ub_n_o}),
                  32'({e.we, e.addr, e.lb_n, e.ub_n}));
            if (e.we) check("txn_wdata", 32'(sram_dq_o), 32'(e.data));
            if (e.start_slot >= 0) check("txn_slot", 32'(slot_i), 32'(e.start_slot));
            run_wr = e.we;
          end
        end
        if (act) begin
          run_len++;
          if (!sram_we_n_o) run_we++;
          if (!sram_oe_n_o) run_oe++;
        end
        if (!act && txn_prev) begin
          if (run_wr) begin
            check("wr_we_len", 32'(run_we), 32'd1);
            check("wr_dqoe_len", 32'(run_len), 32'd2);
          end else begin
            check("rd_oe_len", 32'(run_oe), 32'd2);
          end
          run_len = 0; run_we = 0; run_oe = 0;
        end

        if (cpu_reply_o && !reply_prev) begin
          if (exp_q.size() == 0) begin
            check("reply_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("reply_owner", 32'(e.is_dbg), 32'd0);
            if (!e.we) check("cpu_din", 32'(cpu_din_o), 32'(e.data));
          end
        end
        if (ack_prev) check("ack_width", 32'(dbg_ack_o), 32'd0);
        if (dbg_ack_o && !ack_prev) begin
          if (exp_q.size() == 0) begin
            check("ack_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("ack_owner", 32'(e.is_dbg), 32'd1);
            if (!e.we) check("dbg_rdata", 32'(dbg_rdata_o), 32'(e.data));
          end
        end
        txn_prev   = act;
        reply_prev = cpu_reply_o;
        ack_prev   = dbg_ack_o;
      end
    end
  end

  // Directed stimulus
  initial begin
    int hits;
    reset_in    = 1'b1;
    vid_addr_i  = 13'h0ABC;
    cpu_rd_i    = 1'b0;
    cpu_wt_i    = 1'b0;
    cpu_adr_i   = 16'h0000;
    cpu_byte_i  = 1'b0;
    cpu_dout_i  = 16'h0000;
    dbg_req_i   = 1'b0;
    dbg_we_i    = 1'b0;
    dbg_addr_i  = 18'h0;
    dbg_wdata_i = 16'h0;

    repeat (3) tick();
    check("rst_flags", 32'({cpu_reply_o, dbg_ack_o, vid_load_o, sram_oe_n_o, sram_we_n_o,
                            sram_lb_n_o, sram_ub_n_o, sram_dq_oe_o}), 32'h1E);
    check("rst_addr", 32'(sram_addr_o), 32'd0);
    check("rst_din", 32'(cpu_din_o), 32'd0);
    check("rst_rdata", 32'(dbg_rdata_o), 32'd0);
    reset_in = 1'b0;

    // Two idle frames: only video traffic
    repeat (36) tick();

    // Word read at octal 1000 -> word 0x100; granted slot 3, strobes from slot 4
    wait_slot(4'd3);
    push_exp(1'b0, 1'b0, 18'h00100, 16'h1234, 1'b0, 1'b0, 4);
    cpu_access(1'b0, 16'o1000, 1'b0, 16'h0000);

    // Odd-byte write -> upper lane only
    wait_slot(4'd6);
    push_exp(1'b0, 1'b1, 18'h02000, 16'hAA55, 1'b1, 1'b0, 7);
    cpu_access(1'b1, 16'h4001, 1'b1, 16'hAA55);

    // Request in slot 14 waits out 15/0, granted in slot 1, strobes from slot 2
    wait_slot(4'd14);
    push_exp(1'b0, 1'b0, 18'h00800, 16'h525A, 1'b0, 1'b0, 2);
    fork
      cpu_access(1'b0, 16'h1000, 1'b0, 16'h0000);
      begin
        tick();
        check("bnd_s15_bus", 32'({sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}), 32'b110);
        tick();
        check("bnd_s0_bus", 32'({sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}), 32'b110);
        tick();
        check("bnd_s1_bus", 32'({sram_we_n_o, sram_dq_oe_o}), 32'b10);
      end
    join

    // Reset during the ACC cycle of a write
    wait_slot(4'd5);
    cpu_adr_i  = 16'h0100;
    cpu_byte_i = 1'b0;
    cpu_dout_i = 16'h1111;
    cpu_wt_i   = 1'b1;
    @(posedge clk25);
    #3;
    check("pre_rst_we_n", 32'(sram_we_n_o), 32'd0);
    reset_in = 1'b1;
    #1;
    check("rst_abort_bus", 32'({sram_we_n_o, sram_dq_oe_o, sram_oe_n_o}), 32'b101);
    check("rst_abort_din", 32'(cpu_din_o), 32'd0);
    check("rst_abort_reply", 32'(cpu_reply_o), 32'd0);
    cpu_wt_i = 1'b0;
    tick();
    tick();
    reset_in = 1'b0;
    hits = 0;
    repeat (40) begin
      tick();
      if (cpu_reply_o || dbg_ack_o) hits++;
    end
    check("no_reply_after_rst", 32'(hits), 32'd0);

    // Contention right after reset: CPU write first, then debug read
    wait_slot(4'd14);
    push_exp(1'b0, 1'b1, 18'h00008, 16'hC0DE, 1'b0, 1'b0, 2);
    push_exp(1'b1, 1'b0, 18'h08000, 16'hBEEF, 1'b0, 1'b0, 5);
    fork
      cpu_access(1'b1, 16'h0010, 1'b0, 16'hC0DE);
      dbg_access(1'b0, 18'h08000, 16'h0000);
    join

    repeat (20) tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("dbg_rdata_hold", 32'(dbg_rdata_o), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
